// File: rtl/difftest_step_batcher.sv
// difftest_step_batcher: batches per-cycle commit step counts into checker
// requests over a valid/ready handshake and latches the checker's verdict
// as a sticky simv_result (0 running, 1 done, other nonzero codes fail).
module difftest_step_batcher #(
  parameter int STEP_WIDTH    = 8,
  parameter int ACC_WIDTH     = 16,
  parameter int BATCH_THRESH  = 64,
  parameter int FLUSH_TIMEOUT = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic                  flush,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [ACC_WIDTH-1:0]  req_count,
  input  logic                  rsp_valid,
  input  logic [7:0]            rsp_result,
  output logic [7:0]            simv_result,
  output logic                  busy,
  output logic                  overflow,
  output logic                  protocol_err
);

  localparam int TW = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [TW-1:0]        TIMEOUT = TW'(FLUSH_TIMEOUT);
  localparam logic [ACC_WIDTH-1:0] THRESH  = ACC_WIDTH'(BATCH_THRESH);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

  typedef enum logic [1:0] {S_ACCUM, S_REQ, S_WAIT, S_HALT} state_t;

  state_t                r_state;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [TW-1:0]         r_idle;
  logic                  r_req_valid;
  logic [ACC_WIDTH-1:0]  r_req_count;
  logic [7:0]            r_simv;
  logic                  r_busy;
  logic                  r_overflow;
  logic                  r_perr;

  logic [ACC_WIDTH:0]    w_sum;
  logic                  w_sat;
  logic [ACC_WIDTH-1:0]  w_acc_next;
  logic [TW-1:0]         w_idle_next;
  logic                  w_trigger;

  // Saturating accumulate, idle-timer advance and batch trigger from registered state
  always_comb begin
    w_sum       = {1'b0, r_acc} + (ACC_WIDTH+1)'(step);
    w_sat       = w_sum[ACC_WIDTH];
    w_acc_next  = w_sat ? ACC_MAX : w_sum[ACC_WIDTH-1:0];
    w_idle_next = r_idle;
    if (step != '0)            w_idle_next = '0;
    else if (r_idle < TIMEOUT) w_idle_next = r_idle + 1'b1;
    w_trigger = (r_acc >= THRESH) ||
                ((r_acc != '0) && (r_idle >= TIMEOUT)) ||
                (flush && (r_acc != '0));
  end

  // Batch FSM; all outputs are registered alongside the state
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_ACCUM;
      r_acc       <= '0;
      r_idle      <= '0;
      r_req_valid <= 1'b0;
      r_req_count <= '0;
      r_simv      <= '0;
      r_busy      <= 1'b0;
      r_overflow  <= 1'b0;
      r_perr      <= 1'b0;
    end else begin
      // A verdict is only legal while waiting for one
      if (rsp_valid && (r_state != S_WAIT)) r_perr <= 1'b1;
      // Steps keep counting in every live state; the trigger cycle overrides below
      if (r_state != S_HALT) begin
        r_acc  <= w_acc_next;
        r_idle <= w_idle_next;
        if (w_sat) r_overflow <= 1'b1;
      end
      case (r_state)
        S_ACCUM: if (w_trigger) begin
          // Ship the registered total; this cycle's step starts the next batch
          r_req_count <= r_acc;
          r_acc       <= ACC_WIDTH'(step);
          r_idle      <= '0;
          r_overflow  <= r_overflow;
          r_req_valid <= 1'b1;
          r_busy      <= 1'b1;
          r_state     <= S_REQ;
        end
        S_REQ: if (req_ready) begin
          r_req_valid <= 1'b0;
          r_state     <= S_WAIT;
        end
        S_WAIT: if (rsp_valid) begin
          if (rsp_result == 8'h00) begin
            r_busy  <= 1'b0;
            r_state <= S_ACCUM;
          end else begin
            r_simv  <= rsp_result;
            r_busy  <= 1'b0;
            r_state <= S_HALT;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_valid    = r_req_valid;
  assign req_count    = r_req_count;
  assign simv_result  = r_simv;
  assign busy         = r_busy;
  assign overflow     = r_overflow;
  assign protocol_err = r_perr;

endmodule

// File: doc/difftest_step_batcher.md
Name: difftest_step_batcher

Overview:
Sits directly upstream of the simulation endpoint's result path. It accumulates per-cycle commit step counts from the DUT into batches and issues one batched check request per batch to the host-side checker over a valid/ready handshake. It captures the checker's verdict and presents it as a sticky 8-bit simv_result, so the endpoint sees 0 (running), 1 (done) or 2 (fail) without a per-cycle host call.

Parameters:
STEP_WIDTH, 8, width of per-cycle step input
ACC_WIDTH, 16, width of accumulator and request count
BATCH_THRESH, 64, accumulated steps that force a request
FLUSH_TIMEOUT, 256, step-free cycles after which a non-empty batch is flushed

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
step  in  STEP_WIDTH  instructions committed this cycle (0 = none)
flush  in  1  single-cycle pulse forcing a request if accumulator non-zero
req_valid  out  1  batched request valid
req_ready  in  1  checker accepts request
req_count  out  ACC_WIDTH  steps in the request; stable while req_valid
rsp_valid  in  1  checker verdict valid (single cycle)
rsp_result  in  8  verdict: 0 continue, nonzero terminal code
simv_result  out  8  sticky verdict to endpoint
busy  out  1  request outstanding (REQ or WAIT)
overflow  out  1  sticky: accumulator saturated
protocol_err  out  1  sticky: rsp_valid outside WAIT

Behaviour:
- Reset: state ACCUM; acc=0, idle_timer=0, req_valid=0, req_count=0, simv_result=0, busy=0, overflow=0, protocol_err=0. Reset in any state, including WAIT, discards the outstanding request; a later rsp_valid is then a protocol_err.
- Accumulation (all states except HALT): acc_next = acc + zero-extended step, saturating at 2^ACC_WIDTH-1; saturation sets overflow. idle_timer clears on step!=0, otherwise increments, saturating at FLUSH_TIMEOUT.
- Trigger, evaluated in ACCUM on registered values: acc >= BATCH_THRESH, or (acc != 0 and idle_timer >= FLUSH_TIMEOUT), or (flush and acc != 0). flush with acc==0 is ignored.
- ACCUM -> REQ on trigger: req_count <= acc; acc <= step of that same cycle, so no step is lost; idle_timer <= 0; req_valid=1 from the next cycle.
- REQ: req_valid=1, req_count held. On req_valid&&req_ready -> WAIT, req_valid=0 the next cycle. Steps keep accumulating into acc; triggers are not evaluated. A flush pulse in REQ or WAIT is dropped.
- WAIT: on rsp_valid: rsp_result==0 -> ACCUM, and the trigger is re-evaluated from the following cycle, so back-to-back batches are possible; rsp_result!=0 -> simv_result <= rsp_result, go HALT.
- HALT: terminal until reset. simv_result held, req_valid=0, acc frozen, step ignored.
- rsp_valid in ACCUM, REQ or HALT: ignored, sets protocol_err. rsp_valid coinciding with the REQ handshake cycle is also a protocol_err.
- busy = (state==REQ || state==WAIT).
- Latency: trigger condition true at edge N -> req_valid high after edge N+1. rsp_valid at edge M -> simv_result visible after M+1.
- All outputs are registered.

Test Plan:
- Threshold: step=8 for 8 cycles, req_ready=1 -> one request with req_count=64, busy=1; rsp 0 -> ACCUM, acc=0.
- Timeout flush: step=3 once, then 0 for 256 cycles -> req_valid asserted with req_count=3 exactly 257 cycles after the step edge ±1 per the latency rule; check the edge.
- Backpressure: trigger at 64 with req_ready=0 for 10 cycles while step=1 -> req_count stays 64; after the handshake and rsp 0, a second request has req_count = 1 (trigger-cycle step) + 10 + the further steps.
- Failure: rsp_result=8'h02 in WAIT -> simv_result=2 the next cycle; later step=255 and flush produce no req_valid; simv_result remains 2 until reset.
- Saturation/errors: ACC_WIDTH=8, BATCH_THRESH=255, step=200 twice -> overflow=1, req_count=255. Separately, rsp_valid while in ACCUM -> protocol_err=1, state unchanged.
- Reset mid-operation: reset asserted in WAIT -> all outputs 0 next cycle; subsequent rsp_valid sets protocol_err; a new batch of 64 steps issues normally.
